// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one equality comparator between the branch unit (port 0)
// and the compare/set unit (port 1), with registered operands, result and grant counters.
module cmp_arbiter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              resp_valid,
    output logic              resp_id,
    output logic              resp_zero,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] cmp_rd1,
    output logic [DATA_W-1:0] cmp_rd2,
    input  logic              cmp_zero,
    output logic [CNT_W-1:0]  grant0_cnt,
    output logic [CNT_W-1:0]  grant1_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              id_q, id_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_id_q, resp_id_d;
    logic              resp_zero_q, resp_zero_d;
    logic [CNT_W-1:0]  cnt0_q, cnt0_d;
    logic [CNT_W-1:0]  cnt1_q, cnt1_d;
    logic              grant_vld_s;
    logic              grant_s;

    // Grant selection: only in IDLE, blocked by flush/reset; ties go to the port not granted last.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_s     = 1'b0;
        if ((state_q == S_IDLE) && !flush && !rst) begin
            if (req0_valid && req1_valid) begin
                grant_vld_s = 1'b1;
                grant_s     = ~last_grant_q;
            end else if (req0_valid) begin
                grant_vld_s = 1'b1;
                grant_s     = 1'b0;
            end else if (req1_valid) begin
                grant_vld_s = 1'b1;
                grant_s     = 1'b1;
            end else begin
                grant_vld_s = 1'b0;
                grant_s     = 1'b0;
            end
        end else begin
            grant_vld_s = 1'b0;
            grant_s     = 1'b0;
        end
    end

    assign req0_ready = grant_vld_s & ~grant_s;
    assign req1_ready = grant_vld_s & grant_s;

    // Next-state, operand capture, response and counter update.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_zero_d  = resp_zero_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        case (state_q)
            S_IDLE: begin
                if (grant_vld_s) begin
                    state_d      = S_CMP;
                    last_grant_d = grant_s;
                    id_d         = grant_s;
                    if (grant_s) begin
                        op_a_d = req1_a;
                        op_b_d = req1_b;
                        if (cnt1_q != {CNT_W{1'b1}}) begin
                            cnt1_d = cnt1_q + CNT_ONE;
                        end else begin
                            cnt1_d = cnt1_q;
                        end
                    end else begin
                        op_a_d = req0_a;
                        op_b_d = req0_b;
                        if (cnt0_q != {CNT_W{1'b1}}) begin
                            cnt0_d = cnt0_q + CNT_ONE;
                        end else begin
                            cnt0_d = cnt0_q;
                        end
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CMP: begin
                if (flush) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                end else begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_id_d    = id_q;
                    resp_zero_d  = cmp_zero;
                end
            end
            S_RESP: begin
                if (flush || resp_ready) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d      = S_IDLE;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_zero_q  <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_zero_q  <= resp_zero_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign cmp_rd1    = op_a_q;
    assign cmp_rd2    = op_b_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_zero  = resp_zero_q;
    assign grant0_cnt = cnt0_q;
    assign grant1_cnt = cnt1_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter: per-cycle vector table plus arbitration, saturation and reset sequences.
module tb_cmp_arbiter;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        req0_valid, req1_valid, resp_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready, resp_valid, resp_id, resp_zero;
    logic [31:0] cmp_rd1, cmp_rd2;
    logic        cmp_zero;
    logic [15:0] grant0_cnt, grant1_cnt;
    logic        s_req0_ready, s_req1_ready, s_resp_valid, s_resp_id, s_resp_zero;
    logic [31:0] s_cmp_rd1, s_cmp_rd2;
    logic        s_cmp_zero;
    logic [1:0]  s_grant0_cnt, s_grant1_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Behavioural comparators standing in for the shared equality unit.
    assign cmp_zero   = (cmp_rd1 == cmp_rd2);
    assign s_cmp_zero = (s_cmp_rd1 == s_cmp_rd2);

    cmp_arbiter #(.DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_zero(resp_zero), .resp_ready(resp_ready),
        .cmp_rd1(cmp_rd1), .cmp_rd2(cmp_rd2), .cmp_zero(cmp_zero),
        .grant0_cnt(grant0_cnt), .grant1_cnt(grant1_cnt)
    );

    cmp_arbiter #(.DATA_W(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .resp_valid(s_resp_valid), .resp_id(s_resp_id), .resp_zero(s_resp_zero), .resp_ready(resp_ready),
        .cmp_rd1(s_cmp_rd1), .cmp_rd2(s_cmp_rd2), .cmp_zero(s_cmp_zero),
        .grant0_cnt(s_grant0_cnt), .grant1_cnt(s_grant1_cnt)
    );

    typedef struct {
        logic        r0v;
        logic [31:0] r0a;
        logic [31:0] r0b;
        logic        r1v;
        logic [31:0] r1a;
        logic [31:0] r1b;
        logic        fl;
        logic        rr;
        logic        e0r;
        logic        e1r;
        logic        evld;
        logic        eid;
        logic        ezero;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                         input logic fl, input logic rr);
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        flush = fl; resp_ready = rr;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

        // r0v a b r1v a b fl rr | e0r e1r evld eid ezero
        vecs[0]  = '{1'b1, 32'd5, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 32'd0, 32'd0, 1'b1, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 32'd0, 32'd0, 1'b1, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 32'd0, 32'd0, 1'b1, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 32'd0, 32'd0, 1'b1, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 32'd0, 32'd0, 1'b1, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 32'd0, 32'd0, 1'b1, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 32'd0, 32'd2, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 32'd0, 32'd0, 1'b1, 32'd9, 32'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 32'd0, 32'd0, 1'b1, 32'd9, 32'd9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[17] = '{1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state
        step();
        step();
        @(negedge clk);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_id", {31'd0, resp_id}, 32'd0);
        chk("rst_resp_zero", {31'd0, resp_zero}, 32'd0);
        chk("rst_cmp_rd1", cmp_rd1, 32'd0);
        chk("rst_cmp_rd2", cmp_rd2, 32'd0);
        chk("rst_grant0_cnt", {16'd0, grant0_cnt}, 32'd0);
        chk("rst_grant1_cnt", {16'd0, grant1_cnt}, 32'd0);
        step();
        rst = 1'b0;

        // Single-port op, held response, flush in CMP, flush blocking IDLE accept
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].r0v, vecs[i].r0a, vecs[i].r0b, vecs[i].r1v, vecs[i].r1a, vecs[i].r1b,
                  vecs[i].fl, vecs[i].rr);
            @(negedge clk);
            chk($sformatf("vec%0d_req0_ready", i), {31'd0, req0_ready}, {31'd0, vecs[i].e0r});
            chk($sformatf("vec%0d_req1_ready", i), {31'd0, req1_ready}, {31'd0, vecs[i].e1r});
            chk($sformatf("vec%0d_resp_valid", i), {31'd0, resp_valid}, {31'd0, vecs[i].evld});
            if (vecs[i].evld) begin
                chk($sformatf("vec%0d_resp_id", i), {31'd0, resp_id}, {31'd0, vecs[i].eid});
                chk($sformatf("vec%0d_resp_zero", i), {31'd0, resp_zero}, {31'd0, vecs[i].ezero});
            end
            step();
        end
        chk("tbl_grant0_cnt", {16'd0, grant0_cnt}, 32'd2);
        chk("tbl_grant1_cnt", {16'd0, grant1_cnt}, 32'd2);
        chk("tbl_cmp_rd1_hold", cmp_rd1, 32'd9);
        chk("tbl_cmp_rd2_hold", cmp_rd2, 32'd9);

        // Both ports valid continuously: grants alternate starting with port 0
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i, i, 1'b1, i, i + 1, 1'b0, 1'b1);
            @(negedge clk);
            chk($sformatf("rr%0d_req0_ready", i), {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("rr%0d_req1_ready", i), {31'd0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            step();
            drive(1'b1, 32'hdead, 32'hbeef, 1'b1, 32'hcafe, 32'hcafe, 1'b0, 1'b1);
            @(negedge clk);
            chk($sformatf("rr%0d_cmp_busy", i), {30'd0, req0_ready, req1_ready}, 32'd0);
            step();
            @(negedge clk);
            chk($sformatf("rr%0d_resp_valid", i), {31'd0, resp_valid}, 32'd1);
            chk($sformatf("rr%0d_resp_id", i), {31'd0, resp_id}, (i % 2 == 1) ? 32'd1 : 32'd0);
            chk($sformatf("rr%0d_resp_zero", i), {31'd0, resp_zero}, (i % 2 == 0) ? 32'd1 : 32'd0);
            step();
        end
        chk("rr_grant0_cnt", {16'd0, grant0_cnt}, 32'd6);
        chk("rr_grant1_cnt", {16'd0, grant1_cnt}, 32'd6);

        // Five more port-0 ops: 16-bit counter keeps counting, 2-bit counter stays at 3
        drive(1'b1, 32'd3, 32'd4, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) step();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        step();
        @(negedge clk);
        chk("sat_grant0_cnt_w16", {16'd0, grant0_cnt}, 32'd11);
        chk("sat_grant0_cnt_w2", {30'd0, s_grant0_cnt}, 32'd3);
        chk("sat_grant1_cnt_w2", {30'd0, s_grant1_cnt}, 32'd3);
        step();

        // Reset while in RESP
        drive(1'b1, 32'd1, 32'd1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        step();
        @(negedge clk);
        chk("prerst_resp_valid", {31'd0, resp_valid}, 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rstresp_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rstresp_resp_zero", {31'd0, resp_zero}, 32'd0);
        chk("rstresp_cmp_rd1", cmp_rd1, 32'd0);
        chk("rstresp_grant0_cnt", {16'd0, grant0_cnt}, 32'd0);
        chk("rstresp_grant1_cnt", {16'd0, grant1_cnt}, 32'd0);
        chk("rstresp_sat_cnt", {30'd0, s_grant0_cnt}, 32'd0);
        drive(1'b1, 32'd7, 32'd7, 1'b1, 32'd7, 32'd8, 1'b0, 1'b1);
        #1;
        chk("rstresp_first_grant0", {30'd0, req0_ready, req1_ready}, 32'd2);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
